// File: rtl/qupls_decode_buffer_if.sv
// Decode-to-rename handshake bundle: decoder output word, decoder enable,
// and the head-of-buffer valid/ready pair presented to rename.
interface qupls_decode_buffer_if #(
    parameter int WIDTH = 32
);
    logic             dec_en;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Buffer side.
    modport slave (
        input  dec_valid, dec_data, out_ready,
        output dec_en, out_valid, out_data
    );

    // Decoder + rename side.
    modport master (
        output dec_valid, dec_data, out_ready,
        input  dec_en, out_valid, out_data
    );
endinterface

// File: rtl/qupls_decode_buffer.sv
// Elastic FIFO between decoder and rename; drives the decoder enable so a word
// already inside the decoder's output register always finds a free slot.
module qupls_decode_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    qupls_decode_buffer_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_full, w_enq, w_deq, w_drop;
    logic [CW:0] w_need;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_enq  = bus.dec_valid & ~i_flush & ~w_full;
    assign w_drop = bus.dec_valid & ~i_flush &  w_full;
    assign w_deq  = bus.out_valid & bus.out_ready;

    // Reserve a slot for the word the decoder may already be registering,
    // ignoring out_ready so rename stays out of this path.
    assign w_need     = {1'b0, r_count} + (CW+1)'(bus.dec_valid);
    assign bus.dec_en = ~i_rst & ~i_flush & (w_need < (CW+1)'(DEPTH));

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_ovf         = r_ovf;

    always_ff @(posedge i_clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= bus.dec_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            // A full buffer never accepts, so a same-cycle deq just drains one.
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            if (w_drop) r_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qupls_decode_buffer.sv
// Directed bench for qupls_decode_buffer (DEPTH=4): scoreboard queue for the
// output stream plus per-cycle checks of count, enable, valid and overflow.
module tb_qupls_decode_buffer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic       ovf;

    qupls_decode_buffer_if #(.WIDTH(WIDTH)) bus ();

    qupls_decode_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus.slave),
        .o_count (count),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];
    int  m_cnt   = 0;
    bit  m_ovf   = 1'b0;
    bit  known   = 1'b0;
    bit  prev_en = 1'b0;
    logic [WIDTH-1:0] seq = 16'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake outside reset/flush must match the queue head.
    always @(negedge clk) begin
        if (!rst && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out_data: got %0h with no word expected at %0t", bus.out_data, $time);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock: drive inputs, check at negedge against the model, then advance.
    task automatic cyc(input bit r, input bit fl, input bit dv, input bit rdy, input logic [WIDTH-1:0] d);
        bit enq, deq;
        rst = r; flush = fl;
        bus.dec_valid = dv; bus.dec_data = d; bus.out_ready = rdy;
        @(negedge clk);
        chk("dec_en", 32'(bus.dec_en), 32'(!r && !fl && (m_cnt + int'(dv)) < DEPTH));
        if (known) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("out_valid", 32'(bus.out_valid), 32'(m_cnt != 0));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
        prev_en = bus.dec_en;
        enq = dv && !fl && m_cnt < DEPTH;
        deq = (m_cnt != 0) && rdy;
        if (r) begin
            m_cnt = 0; m_ovf = 0; known = 1; exp_q.delete();
        end else if (fl) begin
            m_cnt = 0; exp_q.delete();
        end else begin
            if (dv && m_cnt == DEPTH) m_ovf = 1;
            if (enq) exp_q.push_back(d);
            m_cnt = m_cnt + int'(enq) - int'(deq);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit rdy);
        cyc(0, 0, 1, rdy, seq);
        seq++;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 16'h0);
    endtask

    initial begin
        bus.dec_valid = 0; bus.dec_data = '0; bus.out_ready = 0;
        @(posedge clk); #1;

        // Reset for two cycles, then idle.
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        idle(0, 1);

        // Streaming with rename always ready: count holds at 1.
        for (int i = 0; i < 10; i++) push(1);
        idle(1, 2);

        // Fill against back-pressure with a decoder that honours dec_en,
        // then drain; three rounds to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            prev_en = 0;
            for (int i = 0; i < 9; i++) begin
                if (prev_en) push(0);
                else cyc(0, 0, 0, 0, 16'h0);
            end
            chk("fill_count", 32'(count), 32'(DEPTH));
            chk("fill_no_ovf", 32'(ovf), 32'(0));
            idle(1, 5);
        end

        // Simultaneous enq/deq at count=2.
        push(0); push(0);
        push(1); push(1); push(1);
        chk("steady_count", 32'(count), 32'd2);

        // Rogue decoder into a full buffer: word dropped, ovf sticks.
        push(0); push(0);
        cyc(0, 0, 1, 0, 16'hDEAD);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        idle(1, 5);

        // Flush with three entries and a word arriving in the same cycle.
        push(0); push(0); push(0);
        cyc(0, 1, 1, 1, 16'hBAD0);
        cyc(0, 0, 0, 0, 16'h0);
        chk("flush_count", 32'(count), 32'd0);
        push(1); push(1);
        idle(1, 3);

        // Reset while full and flushing clears everything including ovf.
        push(0); push(0); push(0); push(0);
        cyc(1, 1, 1, 1, 16'hBAD1);
        cyc(0, 0, 0, 0, 16'h0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        push(1);
        idle(1, 3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
